// File: rtl/cdb_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : cdb_arbiter_pkg                                                 |
// | Purpose  : Shared CDB types and sizing constants used by the CDB arbiter,  |
// |            the reservation stations and the ROB.                           |
// | Contents : NUM_FU, CDB_WIDTH, CDB_PACKET.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_IDX_LEN
`define ROB_IDX_LEN 5
`endif

package cdb_arbiter_pkg;

  localparam int NUM_FU    = 6;
  localparam int CDB_WIDTH = 2;

  // One CDB slot: result broadcast to the ROB complete port and RS wakeup.
  typedef struct packed {
    logic                    valid;
    logic [`ROB_IDX_LEN-1:0] rob_idx;
    logic [`XLEN-1:0]        value;
    logic                    wrong_pred;
  } CDB_PACKET;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_select_n.sv
// +----------------------------------------------------------------------------+
// | Module   : rr_select_n                                                     |
// | Purpose  : Combinational circular priority picker. Scans requests from     |
// |            start_i upward (mod NUM_FU) and hands the first CDB_WIDTH hits  |
// |            to slots 0..CDB_WIDTH-1 in scan order.                          |
// | Ports    : req_i      - request vector                                     |
// |            start_i    - highest-priority index                             |
// |            grant_o    - one one-hot grant vector per slot                  |
// |            any_o      - at least one grant issued                          |
// |            last_idx_o - index of the last granted requester                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_select_n
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
  parameter int CDB_WIDTH = cdb_arbiter_pkg::CDB_WIDTH,
  parameter int PTR_LEN   = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]                 req_i,
  input  logic [PTR_LEN-1:0]                start_i,
  output logic [CDB_WIDTH-1:0][NUM_FU-1:0]  grant_o,
  output logic                              any_o,
  output logic [PTR_LEN-1:0]                last_idx_o
);

  int w_cnt;
  int w_idx;

  always_comb begin
    grant_o    = '0;
    any_o      = 1'b0;
    last_idx_o = '0;
    w_cnt      = 0;
    w_idx      = 0;
    for (int off = 0; off < NUM_FU; off++) begin
      w_idx = int'(start_i) + off;
      if (w_idx >= NUM_FU) begin
        w_idx = w_idx - NUM_FU;
      end
      // Scan order defines slot order, so slot 0 always fills first.
      if (req_i[w_idx] && (w_cnt < CDB_WIDTH)) begin
        grant_o[w_cnt][w_idx] = 1'b1;
        last_idx_o            = PTR_LEN'(w_idx);
        any_o                 = 1'b1;
        w_cnt                 = w_cnt + 1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                     |
// | Purpose  : Round-robin arbitration of functional-unit results onto the     |
// |            multi-slot common data bus, registered with 1-cycle latency.    |
// | Ports    : clock, reset (sync, active-low)                                 |
// |            fu_valid/fu_rob_idx/fu_value/fu_wrong_pred - FU requests        |
// |            squash     - ROB squash_at_head, drops grants and clears bus    |
// |            fu_ready   - per-FU grant (combinational)                       |
// |            cdb_valid/cdb_rob_idx/cdb_value/cdb_wrong_pred - CDB slots      |
// |            rr_ptr     - current highest-priority FU                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
  parameter int CDB_WIDTH = cdb_arbiter_pkg::CDB_WIDTH,
  parameter int PTR_LEN   = $clog2(NUM_FU)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_FU-1:0]                       fu_valid,
  input  logic [NUM_FU-1:0][`ROB_IDX_LEN-1:0]     fu_rob_idx,
  input  logic [NUM_FU-1:0][`XLEN-1:0]            fu_value,
  input  logic [NUM_FU-1:0]                       fu_wrong_pred,
  input  logic                                    squash,
  output logic [NUM_FU-1:0]                       fu_ready,
  output logic [CDB_WIDTH-1:0]                    cdb_valid,
  output logic [CDB_WIDTH-1:0][`ROB_IDX_LEN-1:0]  cdb_rob_idx,
  output logic [CDB_WIDTH-1:0][`XLEN-1:0]         cdb_value,
  output logic [CDB_WIDTH-1:0]                    cdb_wrong_pred,
  output logic [PTR_LEN-1:0]                      rr_ptr
);

  logic [CDB_WIDTH-1:0][NUM_FU-1:0] w_grant;
  logic                             w_any;
  logic [PTR_LEN-1:0]               w_last;
  logic                             w_gate;

  logic [PTR_LEN-1:0]               rr_ptr_q, rr_ptr_d;
  CDB_PACKET [CDB_WIDTH-1:0]        slot_q, slot_d;

  rr_select_n #(
    .NUM_FU    (NUM_FU),
    .CDB_WIDTH (CDB_WIDTH),
    .PTR_LEN   (PTR_LEN)
  ) u_sel (
    .req_i      (fu_valid),
    .start_i    (rr_ptr_q),
    .grant_o    (w_grant),
    .any_o      (w_any),
    .last_idx_o (w_last)
  );

  // Grants only exist outside reset and squash; payload never feeds fu_ready.
  assign w_gate = reset & ~squash;

  always_comb begin
    fu_ready = '0;
    if (w_gate) begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
        fu_ready = fu_ready | w_grant[k];
      end
    end
  end

  // One-hot grants make this an AND-OR mux per slot; unused slots stay zero.
  always_comb begin
    slot_d = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_grant[k][i]) begin
          slot_d[k].valid      = 1'b1;
          slot_d[k].rob_idx    = fu_rob_idx[i];
          slot_d[k].value      = fu_value[i];
          slot_d[k].wrong_pred = fu_wrong_pred[i];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_any) begin
      if (w_last == PTR_LEN'(NUM_FU - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = w_last + PTR_LEN'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      slot_q   <= '0;
    end else if (squash) begin
      slot_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      slot_q   <= slot_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_out
    assign cdb_valid[k]      = slot_q[k].valid;
    assign cdb_rob_idx[k]    = slot_q[k].rob_idx;
    assign cdb_value[k]      = slot_q[k].value;
    assign cdb_wrong_pred[k] = slot_q[k].wrong_pred;
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                                  |
// | Purpose  : Directed self-checking bench for cdb_arbiter (6 FUs, 2 slots).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_IDX_LEN
`define ROB_IDX_LEN 5
`endif

module tb_cdb_arbiter;

  localparam int C_NFU = 6;
  localparam int C_NW  = 2;
  localparam int C_PL  = 3;

  logic                                   clock;
  logic                                   reset;
  logic [C_NFU-1:0]                       fu_valid;
  logic [C_NFU-1:0][`ROB_IDX_LEN-1:0]     fu_rob_idx;
  logic [C_NFU-1:0][`XLEN-1:0]            fu_value;
  logic [C_NFU-1:0]                       fu_wrong_pred;
  logic                                   squash;
  logic [C_NFU-1:0]                       fu_ready;
  logic [C_NW-1:0]                        cdb_valid;
  logic [C_NW-1:0][`ROB_IDX_LEN-1:0]      cdb_rob_idx;
  logic [C_NW-1:0][`XLEN-1:0]             cdb_value;
  logic [C_NW-1:0]                        cdb_wrong_pred;
  logic [C_PL-1:0]                        rr_ptr;

  int r_checks;
  int r_errors;

  cdb_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .fu_valid       (fu_valid),
    .fu_rob_idx     (fu_rob_idx),
    .fu_value       (fu_value),
    .fu_wrong_pred  (fu_wrong_pred),
    .squash         (squash),
    .fu_ready       (fu_ready),
    .cdb_valid      (cdb_valid),
    .cdb_rob_idx    (cdb_rob_idx),
    .cdb_value      (cdb_value),
    .cdb_wrong_pred (cdb_wrong_pred),
    .rr_ptr         (rr_ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, exp finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance past the next posedge so registered outputs are stable.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    r_checks = 0;
    r_errors = 0;
    reset    = 1'b0;
    squash   = 1'b0;
    fu_valid = 6'b111111;
    fu_wrong_pred = '0;
    for (int i = 0; i < C_NFU; i++) begin
      fu_rob_idx[i] = `ROB_IDX_LEN'(i + 10);
      fu_value[i]   = `XLEN'(i * 100 + 1);
    end

    // 1. Reset
    #1;
    chk("rst_ready", 64'(fu_ready), 64'h0);
    tick();
    chk("rst_ready2", 64'(fu_ready), 64'h0);
    tick();
    reset    = 1'b1;
    fu_valid = '0;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_cdb_value", 64'(cdb_value[0]), 64'h0);
    tick();
    chk("rel_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rel_rr_ptr", 64'(rr_ptr), 64'd0);

    // 2. Single request FU2
    fu_valid      = 6'b000100;
    fu_rob_idx[2] = `ROB_IDX_LEN'(5);
    fu_value[2]   = `XLEN'(156);
    #1;
    chk("single_ready", 64'(fu_ready), 64'b000100);
    tick();
    fu_valid = '0;
    chk("single_valid", 64'(cdb_valid), 64'b01);
    chk("single_rob", 64'(cdb_rob_idx[0]), 64'd5);
    chk("single_val", 64'(cdb_value[0]), 64'd156);
    chk("single_ptr", 64'(rr_ptr), 64'd3);
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'b00);
    chk("idle_ptr", 64'(rr_ptr), 64'd3);

    // Return pointer to 0 for the contention case.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_ptr", 64'(rr_ptr), 64'd0);

    // 3. Contention FU0/FU1/FU4
    fu_valid = 6'b010011;
    #1;
    chk("cont_ready", 64'(fu_ready), 64'b000011);
    tick();
    chk("cont_valid", 64'(cdb_valid), 64'b11);
    chk("cont_rob0", 64'(cdb_rob_idx[0]), 64'd10);
    chk("cont_rob1", 64'(cdb_rob_idx[1]), 64'd11);
    chk("cont_val1", 64'(cdb_value[1]), 64'd101);
    chk("cont_ptr", 64'(rr_ptr), 64'd2);
    fu_valid = 6'b010000;
    #1;
    chk("cont2_ready", 64'(fu_ready), 64'b010000);
    tick();
    chk("cont2_valid", 64'(cdb_valid), 64'b01);
    chk("cont2_rob0", 64'(cdb_rob_idx[0]), 64'd14);
    chk("cont2_val0", 64'(cdb_value[0]), 64'd401);
    chk("cont2_ptr", 64'(rr_ptr), 64'd5);

    // 4. Wrap FU5/FU0/FU3, FU5 mispredicted
    fu_valid         = 6'b101001;
    fu_wrong_pred[5] = 1'b1;
    #1;
    chk("wrap_ready", 64'(fu_ready), 64'b100001);
    tick();
    fu_wrong_pred = '0;
    chk("wrap_valid", 64'(cdb_valid), 64'b11);
    chk("wrap_wp", 64'(cdb_wrong_pred), 64'b01);
    chk("wrap_rob0", 64'(cdb_rob_idx[0]), 64'd15);
    chk("wrap_rob1", 64'(cdb_rob_idx[1]), 64'd10);
    chk("wrap_ptr", 64'(rr_ptr), 64'd1);

    // 5. Squash with all FUs valid, then resume
    fu_valid = 6'b111111;
    squash   = 1'b1;
    #1;
    chk("sq_ready", 64'(fu_ready), 64'h0);
    tick();
    squash = 1'b0;
    chk("sq_valid", 64'(cdb_valid), 64'b00);
    chk("sq_ptr", 64'(rr_ptr), 64'd1);
    #1;
    chk("res_ready", 64'(fu_ready), 64'b000110);
    tick();
    chk("res_valid", 64'(cdb_valid), 64'b11);
    chk("res_rob0", 64'(cdb_rob_idx[0]), 64'd11);
    chk("res_rob1", 64'(cdb_rob_idx[1]), 64'd5);
    chk("res_val1", 64'(cdb_value[1]), 64'd156);
    chk("res_ptr", 64'(rr_ptr), 64'd3);

    // 6. Grant FU3, then reset lands before it can be registered
    fu_valid = 6'b001000;
    #1;
    chk("mid_ready", 64'(fu_ready), 64'b001000);
    reset = 1'b0;
    #1;
    chk("mid_ready_rst", 64'(fu_ready), 64'h0);
    tick();
    chk("mid_valid", 64'(cdb_valid), 64'b00);
    chk("mid_ptr", 64'(rr_ptr), 64'd0);
    chk("mid_rob0", 64'(cdb_rob_idx[0]), 64'd0);
    reset    = 1'b1;
    fu_valid = '0;
    tick();
    chk("mid_after_valid", 64'(cdb_valid), 64'b00);
    chk("mid_after_ptr", 64'(rr_ptr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end

endmodule

`default_nettype wire
